// File: rtl/fredkin_shreg.sv
// fredkin_shreg: universal W-bit shift register whose next-state selection and
// mode fan-out are built only from Fredkin (controlled-swap) gates. Each bit is
// stored in a master-slave pair with an asynchronous clear.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low clear (q=0, qb=all ones)
//   mode  - 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sir   - serial input entering bit W-1 on shift right
//   sil   - serial input entering bit 0 on shift left
//   pd    - parallel load data (from upstream latch q outputs)
//   q     - register contents
//   qb    - bitwise complement of q
//   sor   - serial out right, q[0]
//   sol   - serial out left, q[W-1]
module fredkin_shreg #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   mode,
  input  logic         sir,
  input  logic         sil,
  input  logic [W-1:0] pd,
  output logic [W-1:0] q,
  output logic [W-1:0] qb,
  output logic         sor,
  output logic         sol
);

  // mode[0] drives two first-stage gates per bit, mode[1] one second-stage gate
  localparam int unsigned N0 = 2 * W;
  localparam int unsigned N1 = W;

  // Fredkin gate {p, q, r}: p = a; when a=1, b and c are swapped onto q/r
  function automatic logic [2:0] fredkin(input logic a, input logic b, input logic c);
    return {a, (a ? c : b), (a ? b : c)};
  endfunction

  logic [N0-1:0] m0_chain, m0_tap;
  logic [N0-2:0] unused_m0_r;
  logic [N1-1:0] m1_chain, m1_tap;
  logic [N1-2:0] unused_m1_r;

  logic [W-1:0] rsrc, lsrc, x0, x1, nxt;
  logic [W-1:0] unused_s1a_p, unused_s1a_r;
  logic [W-1:0] unused_s1b_p, unused_s1b_r;
  logic [W-1:0] unused_s2_p, unused_s2_r;
  logic [W-1:0] unused_out_p;

  logic [W-1:0] m, s;

  // Copy-gate chains: each gate (a,0,1) -> (a,a,~a); p continues the chain,
  // q is one tap, so every control input is driven by exactly one gate output
  assign m0_chain[0] = mode[0];
  for (genvar k = 0; k < N0 - 1; k++) begin : g_fan0
    assign {m0_chain[k+1], m0_tap[k], unused_m0_r[k]} = fredkin(m0_chain[k], 1'b0, 1'b1);
  end
  assign m0_tap[N0-1] = m0_chain[N0-1];

  assign m1_chain[0] = mode[1];
  for (genvar k = 0; k < N1 - 1; k++) begin : g_fan1
    assign {m1_chain[k+1], m1_tap[k], unused_m1_r[k]} = fredkin(m1_chain[k], 1'b0, 1'b1);
  end
  assign m1_tap[N1-1] = m1_chain[N1-1];

  for (genvar i = 0; i < W; i++) begin : g_bit
    // Neighbour sources; the end bits take the serial inputs, no wrap-around
    if (i == W - 1) begin : g_msb
      assign rsrc[i] = sir;
    end else begin : g_rmid
      assign rsrc[i] = q[i+1];
    end
    if (i == 0) begin : g_lsb
      assign lsrc[i] = sil;
    end else begin : g_lmid
      assign lsrc[i] = q[i-1];
    end

    // Stage 1 (mode[0]): hold vs right source, and left source vs pd
    assign {unused_s1a_p[i], x0[i], unused_s1a_r[i]} = fredkin(m0_tap[2*i], q[i], rsrc[i]);
    assign {unused_s1b_p[i], x1[i], unused_s1b_r[i]} = fredkin(m0_tap[2*i+1], lsrc[i], pd[i]);
    // Stage 2 (mode[1]): pick between the two stage-1 results
    assign {unused_s2_p[i], nxt[i], unused_s2_r[i]} = fredkin(m1_tap[i], x0[i], x1[i]);

    // Output/complement path from the slave: (s,0,1) -> (s, s, ~s)
    assign {unused_out_p[i], q[i], qb[i]} = fredkin(s[i], 1'b0, 1'b1);
  end

  // Master latch: transparent while clk is low
  always_latch begin
    if (!rst_n) begin
      m <= '0;
    end else if (!clk) begin
      m <= nxt;
    end
  end

  // Slave: the master is closed for the whole high phase, so copying it on the
  // rising edge is identical to a transparent-high slave and keeps q glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
    end else begin
      s <= m;
    end
  end

  assign sor = q[0];
  assign sol = q[W-1];

endmodule
